bcd_time_of_day_clock: RTL and testbench

Parametrised BCD time-of-day clock (HH:MM:SS) with an internal second prescaler, a validated parallel time load, runtime 12/24-hour display mode, a programmable alarm comparator and day-rollover signalling. It is the next-generation timekeeping block in the clock datapath. It sits between the system clock and the display/alarm logic, and replaces the fixed hours-minutes structural counter chain.

---
 rtl/bcd_time_of_day_clock.sv | 141 ++++++++++++++
 tb/tb_bcd_time_of_day_clock.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_of_day_clock.sv
// BCD HH:MM:SS time-of-day counter with prescaler, validated time/alarm loads,
// alarm comparator, day-rollover pulse and combinational 12/24-hour presentation.
module bcd_time_of_day_clock #(
    parameter int unsigned DIV = 1,
    parameter int unsigned PW  = 24
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Enable,
    input  logic        Set_time,
    input  logic [23:0] Time_in,
    input  logic        Alarm_set,
    input  logic [23:0] Alarm_in,
    input  logic        Alarm_en,
    input  logic        Mode_12h,
    output logic [23:0] Time_out,
    output logic        PM,
    output logic        Sec_tick,
    output logic        Rollover,
    output logic        Alarm_match,
    output logic        Load_err
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [23:0]   time_q;
    logic [23:0]   alarm_q;
    logic [PW-1:0] count;
    logic          tick;
    logic [23:0]   next_time;
    logic          time_ok;
    logic          alarm_ok;
    logic [4:0]    hour_bin;
    logic [4:0]    disp_hour;

    function automatic logic valid_bcd(input logic [23:0] t);
        logic hour_ok;
        hour_ok = (t[23:20] < 4'd2 && t[19:16] <= 4'd9) ||
                  (t[23:20] == 4'd2 && t[19:16] <= 4'd3);
        return hour_ok && t[15:12] <= 4'd5 && t[11:8] <= 4'd9 &&
               t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
    endfunction

    // Ripple the carry from seconds-ones up to the hour pair, which wraps 23 -> 00.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (t[23:16] == 8'h23) begin
                            r[23:16] = 8'h00;
                        end else if (t[19:16] == 4'd9) begin
                            r[23:20] = t[23:20] + 4'd1;
                            r[19:16] = 4'd0;
                        end else begin
                            r[19:16] = t[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign tick      = Enable && (count == LAST);
    assign next_time = bcd_inc(time_q);
    assign time_ok   = valid_bcd(Time_in);
    assign alarm_ok  = valid_bcd(Alarm_in);

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!Reset_n) begin
            time_q      <= '0;
            alarm_q     <= '0;
            count       <= '0;
            Sec_tick    <= 1'b0;
            Rollover    <= 1'b0;
            Alarm_match <= 1'b0;
            Load_err    <= 1'b0;
        end else begin
            Sec_tick    <= 1'b0;
            Rollover    <= 1'b0;
            Alarm_match <= 1'b0;
            Load_err    <= (Set_time && !time_ok) || (Alarm_set && !alarm_ok);

            if (Alarm_set && alarm_ok) begin
                alarm_q <= Alarm_in;
            end

            // A load always swallows a coincident tick; a rejected load freezes everything.
            if (Set_time) begin
                if (time_ok) begin
                    time_q <= Time_in;
                    count  <= '0;
                end
            end else if (Enable) begin
                if (tick) begin
                    count       <= '0;
                    time_q      <= next_time;
                    Sec_tick    <= 1'b1;
                    Rollover    <= (time_q == 24'h235959);
                    Alarm_match <= Alarm_en && (next_time == alarm_q);
                end else begin
                    count <= count + PW'(1);
                end
            end
        end
    end

    always_comb begin
        hour_bin  = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
        disp_hour = hour_bin;
        Time_out  = time_q;
        PM        = 1'b0;
        if (Mode_12h) begin
            PM = (hour_bin >= 5'd12);
            if (hour_bin == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_bin > 5'd12) begin
                disp_hour = hour_bin - 5'd12;
            end
            Time_out[23:16] = (disp_hour >= 5'd10) ? {4'd1, 4'(disp_hour - 5'd10)}
                                                   : {4'd0, disp_hour[3:0]};
        end
    end

endmodule

// File: tb/tb_bcd_time_of_day_clock.sv
// Bench for bcd_time_of_day_clock: DIV=1 and DIV=5 instances share stimulus and are
// compared every cycle against a seconds-of-day model, plus directed literal checks.
module tb_bcd_time_of_day_clock;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        set_time = 1'b0;
    logic [23:0] time_in = '0;
    logic        alarm_set = 1'b0;
    logic [23:0] alarm_in = '0;
    logic        alarm_en = 1'b0;
    logic        mode_12h = 1'b0;

    logic [1:0][23:0] time_out;
    logic [1:0]       pm, sec_tick, rollover, alarm_match, load_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: time and alarm as seconds of day.
    int divs [2] = '{1, 5};
    int m_sec [2];
    int m_alarm [2];
    int m_cnt [2];
    bit m_tick [2];
    bit m_roll [2];
    bit m_am [2];
    bit m_lerr [2];

    always #5 clk = ~clk;

    bcd_time_of_day_clock #(.DIV(1), .PW(24)) dut0 (
        .CLK(clk), .Reset_n(rst_n), .Enable(enable), .Set_time(set_time),
        .Time_in(time_in), .Alarm_set(alarm_set), .Alarm_in(alarm_in),
        .Alarm_en(alarm_en), .Mode_12h(mode_12h), .Time_out(time_out[0]),
        .PM(pm[0]), .Sec_tick(sec_tick[0]), .Rollover(rollover[0]),
        .Alarm_match(alarm_match[0]), .Load_err(load_err[0])
    );

    bcd_time_of_day_clock #(.DIV(5), .PW(3)) dut1 (
        .CLK(clk), .Reset_n(rst_n), .Enable(enable), .Set_time(set_time),
        .Time_in(time_in), .Alarm_set(alarm_set), .Alarm_in(alarm_in),
        .Alarm_en(alarm_en), .Mode_12h(mode_12h), .Time_out(time_out[1]),
        .PM(pm[1]), .Sec_tick(sec_tick[1]), .Rollover(rollover[1]),
        .Alarm_match(alarm_match[1]), .Load_err(load_err[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [23:0] make_bcd(input int h, input int m, input int s);
        return 24'(((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
                   ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
    endfunction

    function automatic logic [23:0] sec_bcd(input int sec);
        return make_bcd(sec / 3600, (sec / 60) % 60, sec % 60);
    endfunction

    function automatic bit valid_bcd(input logic [23:0] t);
        return int'(t[23:20]) * 10 + int'(t[19:16]) <= 23 && t[19:16] <= 9 &&
               t[15:12] <= 5 && t[11:8] <= 9 && t[7:4] <= 5 && t[3:0] <= 9;
    endfunction

    function automatic int to_sec(input logic [23:0] t);
        int h, m, s;
        h = int'(t[23:20]) * 10 + int'(t[19:16]);
        m = int'(t[15:12]) * 10 + int'(t[11:8]);
        s = int'(t[7:4]) * 10 + int'(t[3:0]);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [23:0] disp_bcd(input int sec, input bit m12);
        int h;
        h = sec / 3600;
        if (m12) begin
            h = h % 12;
            if (h == 0) h = 12;
        end
        return make_bcd(h, (sec / 60) % 60, sec % 60);
    endfunction

    task automatic model_update();
        int old_alarm;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_sec[i] = 0; m_alarm[i] = 0; m_cnt[i] = 0;
                m_tick[i] = 0; m_roll[i] = 0; m_am[i] = 0; m_lerr[i] = 0;
            end else begin
                m_lerr[i] = (set_time && !valid_bcd(time_in)) || (alarm_set && !valid_bcd(alarm_in));
                m_tick[i] = 0; m_roll[i] = 0; m_am[i] = 0;
                old_alarm = m_alarm[i];
                if (alarm_set && valid_bcd(alarm_in)) m_alarm[i] = to_sec(alarm_in);
                if (set_time) begin
                    if (valid_bcd(time_in)) begin
                        m_sec[i] = to_sec(time_in);
                        m_cnt[i] = 0;
                    end
                end else if (enable) begin
                    if (m_cnt[i] == divs[i] - 1) begin
                        m_cnt[i]  = 0;
                        m_roll[i] = (m_sec[i] == 86399);
                        m_sec[i]  = (m_sec[i] + 1) % 86400;
                        m_tick[i] = 1;
                        m_am[i]   = alarm_en && (m_sec[i] == old_alarm);
                    end else begin
                        m_cnt[i]++;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("time_out[%0d]", i), time_out[i], disp_bcd(m_sec[i], mode_12h));
            check($sformatf("pm[%0d]", i), pm[i], mode_12h && (m_sec[i] / 3600 >= 12));
            check($sformatf("sec_tick[%0d]", i), sec_tick[i], m_tick[i]);
            check($sformatf("rollover[%0d]", i), rollover[i], m_roll[i]);
            check($sformatf("alarm_match[%0d]", i), alarm_match[i], m_am[i]);
            check($sformatf("load_err[%0d]", i), load_err[i], m_lerr[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    function automatic logic [23:0] rand_time();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 24'($urandom);
        if (r < 5) return sec_bcd(86400 - $urandom_range(1, 12));
        return sec_bcd($urandom_range(0, 86399));
    endfunction

    logic [23:0] p_in [4]  = '{24'h000000, 24'h115959, 24'h120000, 24'h134501};
    logic [23:0] p_out [4] = '{24'h120000, 24'h115959, 24'h120000, 24'h014501};
    bit          p_pm [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [23:0] bad [3]   = '{24'h246000, 24'h09A000, 24'h125960};

    initial begin
        int ticks, rolls, alarms, first;

        // Reset state in both presentation modes.
        step();
        check("rst_time24", time_out[0], 24'h000000);
        check("rst_flags", {sec_tick, rollover, alarm_match, load_err, pm}, 10'h0);
        mode_12h = 1'b1;
        step();
        check("rst_time12", time_out[0], 24'h120000);
        check("rst_pm12", pm[0], 1'b0);
        mode_12h = 1'b0;

        // 60 enabled cycles at DIV=1 and DIV=5.
        rst_n = 1'b1; enable = 1'b1;
        ticks = 0; rolls = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            ticks += sec_tick[0];
            rolls += rollover[0];
        end
        check("ticks60", ticks, 60);
        check("rolls60", rolls, 0);
        check("time60", time_out[0], 24'h000100);
        check("time60_div5", time_out[1], 24'h000012);

        // Day rollover.
        set_time = 1'b1; time_in = 24'h235959;
        step();
        set_time = 1'b0;
        step();
        check("roll_time", time_out[0], 24'h000000);
        check("roll_pulse", rollover[0], 1'b1);
        check("roll_tick", sec_tick[0], 1'b1);
        step();
        check("roll_once", rollover[0], 1'b0);

        // Rejected loads.
        enable = 1'b0; set_time = 1'b1; time_in = 24'h101010;
        step();
        for (int k = 0; k < 3; k++) begin
            time_in = bad[k];
            step();
            check($sformatf("bad_err%0d", k), load_err[0], 1'b1);
            check($sformatf("bad_hold%0d", k), time_out[0], 24'h101010);
        end
        set_time = 1'b0;
        step();
        check("bad_err_clear", load_err[0], 1'b0);

        // 12-hour presentation.
        mode_12h = 1'b1; set_time = 1'b1;
        for (int k = 0; k < 4; k++) begin
            time_in = p_in[k];
            step();
            check($sformatf("h12_time%0d", k), time_out[0], p_out[k]);
            check($sformatf("h12_pm%0d", k), pm[0], p_pm[k]);
        end
        set_time = 1'b0; mode_12h = 1'b0;

        // Alarm match on increment, none on load.
        alarm_set = 1'b1; alarm_in = 24'h070000; alarm_en = 1'b1;
        set_time = 1'b1; time_in = 24'h065959;
        step();
        alarm_set = 1'b0; set_time = 1'b0; enable = 1'b1;
        alarms = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            alarms += alarm_match[0];
        end
        check("alarm_count", alarms, 1);
        enable = 1'b0; set_time = 1'b1; time_in = 24'h070000;
        step();
        set_time = 1'b0;
        step();
        check("alarm_no_load", alarm_match, 2'b00);

        // DIV=5: three disabled cycles delay the tick by three.
        set_time = 1'b1; time_in = 24'h000000;
        step();
        set_time = 1'b0;
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            enable = !(k >= 3 && k <= 5);
            step();
            if (sec_tick[1]) first = k;
        end
        check("gap_tick_edge", first, 8);

        // Reset mid-count.
        enable = 1'b1; set_time = 1'b1; time_in = 24'h123456;
        step();
        set_time = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_time", time_out, 48'h0);
        check("midrst_flags", {sec_tick, rollover, alarm_match, load_err, pm}, 10'h0);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            enable    = ($urandom_range(0, 9) < 8);
            set_time  = ($urandom_range(0, 29) == 0);
            time_in   = rand_time();
            alarm_set = ($urandom_range(0, 24) == 0);
            alarm_in  = ($urandom_range(0, 9) < 6) ? sec_bcd((m_sec[0] + $urandom_range(1, 10)) % 86400)
                                                   : rand_time();
            alarm_en  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) mode_12h = !mode_12h;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
